// File: rtl/snn_buffer_pkg.sv
// Shared definitions for the accelerator staging buffers.
//   SNN_DATA_WIDTH : default payload width
//   ptr_inc()      : wrap-aware pointer increment, valid for any depth
//                    (not only powers of two)
package snn_buffer_pkg;

  localparam int SNN_DATA_WIDTH = 32;

  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/buffer_storage_ram.sv
// Storage array for stream_data_buffer: DATA_WIDTH x DEPTH, one synchronous
// write port and one asynchronous read port. No reset, so it can map to RAM.
//   clk   : write clock
//   we    : write enable
//   waddr : write address, 0..DEPTH-1
//   wdata : write data
//   raddr : read address, 0..DEPTH-1
//   rdata : read data, combinational from raddr
module buffer_storage_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_data_buffer.sv
// First-word-fall-through FIFO with valid/ready handshakes on both sides,
// arbitrary depth, occupancy count, almost flags and synchronous flush.
//   clk          : clock, rising edge
//   reset        : synchronous active-high, clears pointers and count
//   flush        : synchronous clear of pointers and count
//   wr_valid     : producer has data
//   wr_ready     : buffer can accept (depends only on state and flush)
//   wr_data      : write payload
//   rd_valid     : head entry available
//   rd_ready     : consumer takes head
//   rd_data      : head entry, valid while rd_valid
//   count        : occupancy, 0..DEPTH
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
module stream_data_buffer
  import snn_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = SNN_DATA_WIDTH,
  parameter int DEPTH      = 32,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("stream_data_buffer: DEPTH must be >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("stream_data_buffer: AF_LEVEL must be <= DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("stream_data_buffer: AE_LEVEL must be < DEPTH");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full && !flush;
  assign rd_valid = !empty && !flush;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  // Reset and flush have the same effect; storage is deliberately untouched.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= AW'(ptr_inc(32'(wr_ptr), DEPTH));
      if (pop)  rd_ptr <= AW'(ptr_inc(32'(rd_ptr), DEPTH));
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

  buffer_storage_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_stream_data_buffer.sv
module tb_stream_data_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 32 x 32, AF=30, AE=1
  logic        reset_a, flush_a, wr_valid_a, wr_ready_a, rd_valid_a, rd_ready_a;
  logic [31:0] wr_data_a, rd_data_a;
  logic [5:0]  count_a;
  logic        almost_full_a, almost_empty_a;

  // Instance B: 8 x 5, AF=4, AE=1
  logic        reset_b, flush_b, wr_valid_b, wr_ready_b, rd_valid_b, rd_ready_b;
  logic [7:0]  wr_data_b, rd_data_b;
  logic [2:0]  count_b;
  logic        almost_full_b, almost_empty_b;

  stream_data_buffer #(.DATA_WIDTH(32), .DEPTH(32), .AF_LEVEL(30), .AE_LEVEL(1)) u_a (
    .clk(clk), .reset(reset_a), .flush(flush_a),
    .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_data(wr_data_a),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready_a), .rd_data(rd_data_a),
    .count(count_a), .almost_full(almost_full_a), .almost_empty(almost_empty_a));

  stream_data_buffer #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_b (
    .clk(clk), .reset(reset_b), .flush(flush_b),
    .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_data(wr_data_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b),
    .count(count_b), .almost_full(almost_full_b), .almost_empty(almost_empty_b));

  // Reference contents: a plain FIFO queue per instance.
  logic [31:0] qa[$];
  logic [7:0]  qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle on A: drive at the falling edge, check outputs against the
  // queue model, then advance the model by the handshake rules.
  task automatic step_a(input logic wv, input logic [31:0] wd, input logic rr,
                        input logic fl, input logic rs);
    logic ew, ev;
    int   n;
    @(negedge clk);
    wr_valid_a = wv; wr_data_a = wd; rd_ready_a = rr; flush_a = fl; reset_a = rs;
    #1;
    n  = qa.size();
    ew = (n < 32) && !fl;
    ev = (n > 0) && !fl;
    chk("a_wr_ready", 32'(wr_ready_a), 32'(ew));
    chk("a_rd_valid", 32'(rd_valid_a), 32'(ev));
    chk("a_count", 32'(count_a), 32'(n));
    chk("a_almost_full", 32'(almost_full_a), 32'(n >= 30));
    chk("a_almost_empty", 32'(almost_empty_a), 32'(n <= 1));
    if (ev) chk("a_rd_data", rd_data_a, qa[0]);
    if (rs || fl) qa.delete();
    else begin
      if (ev && rr) void'(qa.pop_front());
      if (ew && wv) qa.push_back(wd);
    end
  endtask

  task automatic step_b(input logic wv, input logic [7:0] wd, input logic rr,
                        input logic fl, input logic rs);
    logic ew, ev;
    int   n;
    @(negedge clk);
    wr_valid_b = wv; wr_data_b = wd; rd_ready_b = rr; flush_b = fl; reset_b = rs;
    #1;
    n  = qb.size();
    ew = (n < 5) && !fl;
    ev = (n > 0) && !fl;
    chk("b_wr_ready", 32'(wr_ready_b), 32'(ew));
    chk("b_rd_valid", 32'(rd_valid_b), 32'(ev));
    chk("b_count", 32'(count_b), 32'(n));
    chk("b_almost_full", 32'(almost_full_b), 32'(n >= 4));
    chk("b_almost_empty", 32'(almost_empty_b), 32'(n <= 1));
    if (ev) chk("b_rd_data", 32'(rd_data_b), 32'(qb[0]));
    if (rs || fl) qb.delete();
    else begin
      if (ev && rr) void'(qb.pop_front());
      if (ew && wv) qb.push_back(wd);
    end
  endtask

  // Hand-computed boundary vectors for instance B: inputs for the cycle and
  // the outputs expected before that cycle's edge.
  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       exp_wr;
    logic       exp_rv;
    logic [2:0] exp_cnt;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tv[14];

  initial begin
    tv[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00}; // empty: push only
    tv[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 8'hA5}; // A5 visible, popped
    tv[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
    tv[3]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 3'd1, 8'h01};
    tv[4]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 3'd2, 8'h01};
    tv[5]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 3'd3, 8'h01};
    tv[6]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 3'd4, 8'h01};
    tv[7]  = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 3'd5, 8'h01}; // full: pop only, 06 dropped
    tv[8]  = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 3'd4, 8'h02}; // mid: push+pop
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 8'h03};
    tv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 8'h04};
    tv[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h05};
    tv[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 8'h07};
    tv[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};

    reset_a = 1'b1; flush_a = 1'b0; wr_valid_a = 1'b0; rd_ready_a = 1'b0; wr_data_a = '0;
    reset_b = 1'b1; flush_b = 1'b0; wr_valid_b = 1'b0; rd_ready_b = 1'b0; wr_data_b = '0;
    repeat (2) @(posedge clk);

    // ---------------- Instance A ----------------
    step_a(0, 0, 0, 0, 0);                         // reset values
    for (int i = 0; i < 32; i++) step_a(1, 32'(i), 0, 0, 0);
    step_a(1, 32'hDEAD, 0, 0, 0);                  // full: wr_ready low
    for (int i = 0; i < 32; i++) step_a(0, 0, 1, 0, 0);
    step_a(0, 0, 1, 0, 0);                         // drained

    // flush with count=7 and concurrent push/pop requests
    for (int i = 0; i < 7; i++) step_a(1, 32'(32'h100 + i), 0, 0, 0);
    step_a(1, 32'hBAD0, 1, 1, 0);
    step_a(1, 32'h3C, 0, 0, 0);
    step_a(0, 0, 1, 0, 0);                         // 3C at head, popped
    step_a(0, 0, 0, 0, 0);

    // reset mid-stream with count=12 while pushing
    for (int i = 0; i < 12; i++) step_a(1, 32'(32'h200 + i), 0, 0, 0);
    step_a(1, 32'hBAD1, 0, 0, 1);
    step_a(0, 0, 0, 0, 0);
    // reset together with flush
    for (int i = 0; i < 12; i++) step_a(1, 32'(32'h300 + i), 0, 0, 0);
    step_a(1, 32'hBAD2, 1, 1, 1);
    step_a(0, 0, 0, 0, 0);
    step_a(1, 32'h55, 0, 0, 0);
    step_a(0, 0, 1, 0, 0);
    step_a(0, 0, 0, 0, 0);

    // ---------------- Instance B: boundary table ----------------
    reset_b = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wr_valid_b = tv[i].wv; wr_data_b = tv[i].wd; rd_ready_b = tv[i].rr;
      flush_b = 1'b0; reset_b = 1'b0;
      #1;
      chk("tv_wr_ready", 32'(wr_ready_b), 32'(tv[i].exp_wr));
      chk("tv_rd_valid", 32'(rd_valid_b), 32'(tv[i].exp_rv));
      chk("tv_count", 32'(count_b), 32'(tv[i].exp_cnt));
      chk("tv_almost_full", 32'(almost_full_b), 32'(tv[i].exp_cnt >= 3'd4));
      chk("tv_almost_empty", 32'(almost_empty_b), 32'(tv[i].exp_cnt <= 3'd1));
      if (tv[i].exp_rv) chk("tv_rd_data", 32'(rd_data_b), 32'(tv[i].exp_data));
    end

    // 13 interleaved pushes so both pointers wrap at least twice
    for (int i = 0; i < 13; i++) step_b(1, 8'(8'h40 + i), qb.size() >= 3, 0, 0);
    for (int i = 0; i < 8; i++) step_b(0, 0, 1, 0, 0);

    // randomised backpressure against the queue model
    for (int i = 0; i < 2000; i++)
      step_b(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) == 0, 0);
    for (int i = 0; i < 8; i++) step_b(0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
